// File: rtl/systolic_tile_feeder.sv
// Operand streamer for an ARR x ARR systolic matmul array.
// Buffers one A/B tile pair and replays it as a skewed diagonal wavefront.
module systolic_tile_feeder #(
  parameter int ARR = 2,
  parameter int EW  = 8,
  localparam int WW = ARR * EW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [16:0]   size,
  input  logic [WW-1:0] a_data,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [WW-1:0] b_data,
  input  logic          b_valid,
  output logic          b_ready,
  output logic [WW-1:0] a_out,
  output logic [WW-1:0] b_out,
  output logic [ARR-1:0] a_lane_vld,
  output logic [ARR-1:0] b_lane_vld,
  output logic          tile_first,
  output logic          tile_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int IW = $clog2(ARR);
  localparam int CW = $clog2(ARR + 1);
  localparam int TW = $clog2(2 * ARR);
  localparam logic [CW-1:0] CNT_FULL = CW'(ARR);
  localparam logic [CW-1:0] CNT_LAST = CW'(ARR - 1);
  localparam logic [TW-1:0] T_LAST = TW'(2 * ARR - 2);
  localparam logic [TW-1:0] T_ARR = TW'(ARR);
  localparam logic [16:0] ARR17 = 17'(ARR);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FEED,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ARR-1:0][EW-1:0] a_row [ARR];
  logic [ARR-1:0][EW-1:0] b_col [ARR];
  logic [CW-1:0] a_cnt, b_cnt;
  logic [TW-1:0] t;
  logic [16:0] nt, ti, tj, tk;
  logic err_q, done_q;

  logic go, size_ok, feed;
  logic a_fire, b_fire, a_full, b_full;
  logic last_step, k_wrap, j_wrap, i_wrap;

  assign feed    = state_q == FEED;
  assign go      = start && (state_q == IDLE || state_q == DONE);
  assign size_ok = size != 17'd0 && (size % ARR17) == 17'd0;

  assign a_ready = state_q == LOAD && a_cnt != CNT_FULL;
  assign b_ready = state_q == LOAD && b_cnt != CNT_FULL;
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid && b_ready;

  // Counts include this cycle's accept so FEED follows the last handshake.
  assign a_full = a_cnt == CNT_FULL || (a_fire && a_cnt == CNT_LAST);
  assign b_full = b_cnt == CNT_FULL || (b_fire && b_cnt == CNT_LAST);

  assign last_step = feed && t == T_LAST;
  assign k_wrap    = tk == nt - 17'd1;
  assign j_wrap    = tj == nt - 17'd1;
  assign i_wrap    = ti == nt - 17'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (go) state_d = size_ok ? LOAD : IDLE;
      end
      LOAD: begin
        if (a_full && b_full) state_d = FEED;
      end
      FEED: begin
        if (last_step) begin
          state_d = (k_wrap && j_wrap && i_wrap) ? DONE : LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_cnt  <= '0;
      b_cnt  <= '0;
      t      <= '0;
      nt     <= '0;
      ti     <= '0;
      tj     <= '0;
      tk     <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (go) begin
        err_q  <= !size_ok;
        done_q <= 1'b0;
        nt     <= size / ARR17;
        ti     <= '0;
        tj     <= '0;
        tk     <= '0;
        a_cnt  <= '0;
        b_cnt  <= '0;
        t      <= '0;
      end
      if (a_fire) a_cnt <= a_cnt + 1'b1;
      if (b_fire) b_cnt <= b_cnt + 1'b1;
      if (feed) begin
        t <= t + 1'b1;
        if (last_step) begin
          t     <= '0;
          a_cnt <= '0;
          b_cnt <= '0;
          // k innermost, then j, then i
          tk <= k_wrap ? 17'd0 : tk + 17'd1;
          if (k_wrap) tj <= j_wrap ? 17'd0 : tj + 17'd1;
          if (k_wrap && j_wrap) ti <= i_wrap ? 17'd0 : ti + 17'd1;
          if (k_wrap && j_wrap && i_wrap) done_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (a_fire) a_row[a_cnt[IW-1:0]] <= a_data;
    if (b_fire) b_col[b_cnt[IW-1:0]] <= b_data;
  end

  logic [ARR-1:0][EW-1:0] a_lane, b_lane;

  // Lane g lags by g steps; negative offsets wrap above ARR and read invalid.
  for (genvar g = 0; g < ARR; g++) begin : g_lane
    logic [TW-1:0] d;
    assign d = t - TW'(g);
    assign a_lane_vld[g] = feed && d < T_ARR;
    assign b_lane_vld[g] = feed && d < T_ARR;
    assign a_lane[g] = a_lane_vld[g] ? a_row[g][d[IW-1:0]] : '0;
    assign b_lane[g] = b_lane_vld[g] ? b_col[g][d[IW-1:0]] : '0;
  end

  assign a_out      = a_lane;
  assign b_out      = b_lane;
  assign tile_first = feed && t == '0 && tk == 17'd0;
  assign tile_last  = last_step && k_wrap;
  assign busy       = state_q == LOAD || state_q == FEED;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_systolic_tile_feeder.sv
// Bench for systolic_tile_feeder: ARR=2/EW=8 and ARR=4/EW=16 instances.
// Scoreboard of expected wavefront steps, popped as FEED steps appear.
module tb_systolic_tile_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start1, start2, sel;
  logic        a_valid, b_valid;
  logic [16:0] size;
  logic [63:0] a_data, b_data;

  logic        a_ready1, b_ready1, first1, last1, busy1, done1, err1;
  logic [15:0] a_out1, b_out1;
  logic [1:0]  am1, bm1;

  logic        a_ready2, b_ready2, first2, last2, busy2, done2, err2;
  logic [63:0] a_out2, b_out2;
  logic [3:0]  am2, bm2;

  systolic_tile_feeder #(.ARR(2), .EW(8)) u_d1 (
    .clk(clk), .reset(reset), .start(start1), .size(size),
    .a_data(a_data[15:0]), .a_valid(a_valid & ~sel), .a_ready(a_ready1),
    .b_data(b_data[15:0]), .b_valid(b_valid & ~sel), .b_ready(b_ready1),
    .a_out(a_out1), .b_out(b_out1), .a_lane_vld(am1), .b_lane_vld(bm1),
    .tile_first(first1), .tile_last(last1),
    .busy(busy1), .done(done1), .err(err1)
  );

  systolic_tile_feeder #(.ARR(4), .EW(16)) u_d2 (
    .clk(clk), .reset(reset), .start(start2), .size(size),
    .a_data(a_data), .a_valid(a_valid & sel), .a_ready(a_ready2),
    .b_data(b_data), .b_valid(b_valid & sel), .b_ready(b_ready2),
    .a_out(a_out2), .b_out(b_out2), .a_lane_vld(am2), .b_lane_vld(bm2),
    .tile_first(first2), .tile_last(last2),
    .busy(busy2), .done(done2), .err(err2)
  );

  logic [63:0] m_a, m_b;
  logic [3:0]  m_am, m_bm;
  logic        m_first, m_last, m_done, m_ar, m_br;
  assign m_a     = sel ? a_out2 : {48'h0, a_out1};
  assign m_b     = sel ? b_out2 : {48'h0, b_out1};
  assign m_am    = sel ? am2 : {2'b0, am1};
  assign m_bm    = sel ? bm2 : {2'b0, bm1};
  assign m_first = sel ? first2 : first1;
  assign m_last  = sel ? last2 : last1;
  assign m_done  = sel ? done2 : done1;
  assign m_ar    = sel ? a_ready2 : a_ready1;
  assign m_br    = sel ? b_ready2 : b_ready1;

  typedef struct {
    logic [63:0] a, b;
    logic [3:0]  am, bm;
    logic        f, l;
    int          t;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [63:0] aw[$], bw[$];
  logic [3:0]  mlog[$];
  int n_assert = 0, n_fail = 0, cyc = 0;
  int n_feed = 0, n_first = 0, n_last = 0;
  int step0_cyc = 0, last_fire_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (m_am != 0 || m_bm != 0 || m_first || m_last) begin
      n_feed++;
      if (m_first) n_first++;
      if (m_last) n_last++;
      if (sel) mlog.push_back(m_am);
      if (q.size() == 0) begin
        chk("unexpected_feed", {60'h0, m_am}, 64'h0);
      end else begin
        me = q.pop_front();
        if (me.t == 0) step0_cyc = cyc;
        chk($sformatf("a_out_t%0d", me.t), m_a, me.a);
        chk($sformatf("b_out_t%0d", me.t), m_b, me.b);
        chk($sformatf("a_mask_t%0d", me.t), {60'h0, m_am}, {60'h0, me.am});
        chk($sformatf("b_mask_t%0d", me.t), {60'h0, m_bm}, {60'h0, me.bm});
        chk($sformatf("first_t%0d", me.t), {63'h0, m_first}, {63'h0, me.f});
        chk($sformatf("last_t%0d", me.t), {63'h0, m_last}, {63'h0, me.l});
      end
    end
  end

  task automatic push_tile(input logic [63:0] ta[4], input logic [63:0] tb[4],
                           input int arr, input int ew, input bit f, input bit l);
    logic [63:0] em;
    exp_t e;
    em = (64'd1 << ew) - 64'd1;
    for (int n = 0; n < arr; n++) begin
      aw.push_back(ta[n]);
      bw.push_back(tb[n]);
    end
    for (int t = 0; t < 2 * arr - 1; t++) begin
      e.a = '0; e.b = '0; e.am = '0; e.bm = '0; e.t = t;
      e.f = f && t == 0;
      e.l = l && t == 2 * arr - 2;
      for (int n = 0; n < arr; n++) begin
        if (t - n >= 0 && t - n < arr) begin
          e.am[n] = 1'b1;
          e.bm[n] = 1'b1;
          e.a |= ((ta[n] >> ((t - n) * ew)) & em) << (n * ew);
          e.b |= ((tb[n] >> ((t - n) * ew)) & em) << (n * ew);
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic push_job(input int sz, input int arr, input int ew);
    logic [63:0] ta[4], tb[4], wm;
    int nt;
    nt = sz / arr;
    wm = (arr * ew >= 64) ? '1 : (64'd1 << (arr * ew)) - 64'd1;
    for (int i = 0; i < nt; i++)
      for (int j = 0; j < nt; j++)
        for (int k = 0; k < nt; k++) begin
          for (int n = 0; n < 4; n++) begin
            ta[n] = {$urandom, $urandom} & wm;
            tb[n] = {$urandom, $urandom} & wm;
          end
          push_tile(ta, tb, arr, ew, k == 0, k == nt - 1);
        end
  endtask

  task automatic start_job(input int sz);
    @(negedge clk);
    size = 17'(sz);
    if (sel) start2 = 1'b1;
    else     start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic run_words(input int b_delay, input bit stall_a,
                           input bit extra_a, input bit stop_at_feed);
    int guard = 0, a_acc = 0, sc = 0;
    bit af, bf;
    while (1) begin
      @(negedge clk);
      if (stop_at_feed ? (aw.size() == 0 && bw.size() == 0) : m_done) break;
      guard++;
      if (guard > 3000) begin
        chk("drive_timeout", {63'h0, m_done}, 64'h1);
        break;
      end
      a_valid = aw.size() > 0 || extra_a;
      if (stall_a && a_acc == 1 && sc < 4) begin
        a_valid = 1'b0;
        sc++;
      end
      a_data  = aw.size() > 0 ? aw[0] : 64'hDEAD_BEEF_DEAD_BEEF;
      b_valid = guard > b_delay && bw.size() > 0;
      b_data  = bw.size() > 0 ? bw[0] : 64'h0;
      af = a_valid && m_ar;
      bf = b_valid && m_br;
      if (extra_a && aw.size() == 0 && a_valid)
        chk("a_ready_extra_word", {63'h0, m_ar}, 64'h0);
      if (af || bf) last_fire_cyc = cyc;
      @(posedge clk);
      if (af) begin
        if (aw.size() > 0) void'(aw.pop_front());
        a_acc++;
      end
      if (bf) void'(bw.pop_front());
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  logic [63:0] ta1[4], tb1[4];
  logic [3:0]  mexp[7];

  initial begin
    reset = 1'b0; start1 = 1'b0; start2 = 1'b0; sel = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; size = '0;
    #1;
    chk("rst_a_ready", {63'h0, a_ready1}, 64'h0);
    chk("rst_b_ready", {63'h0, b_ready1}, 64'h0);
    chk("rst_done", {63'h0, done1}, 64'h0);
    chk("rst_err", {63'h0, err1}, 64'h0);
    chk("rst_busy", {63'h0, busy1}, 64'h0);
    chk("rst_outs", {a_out1, b_out1, am1, bm1, first1, last1}, 64'h0);
    chk("rst_d2", {a_out2[7:0], am2, a_ready2, b_ready2, done2, busy2}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // basic wavefront
    ta1 = '{64'h0201, 64'h0403, 64'h0, 64'h0};
    tb1 = '{64'h0605, 64'h0807, 64'h0, 64'h0};
    push_tile(ta1, tb1, 2, 8, 1'b1, 1'b1);
    start_job(2);
    run_words(0, 1'b0, 1'b0, 1'b0);
    chk("t1_done", {63'h0, done1}, 64'h1);
    chk("t1_q_empty", 64'(q.size()), 64'h0);

    // size 4: 8 pairs, 24 feed cycles
    n_feed = 0; n_first = 0; n_last = 0;
    push_job(4, 2, 8);
    start_job(4);
    run_words(0, 1'b0, 1'b0, 1'b0);
    chk("t2_feed_cycles", 64'(n_feed), 64'd24);
    chk("t2_first_cnt", 64'(n_first), 64'd4);
    chk("t2_last_cnt", 64'(n_last), 64'd4);
    chk("t2_done", {63'h0, done1}, 64'h1);
    chk("t2_q_empty", 64'(q.size()), 64'h0);

    // handshake skew, stall and extra A word
    push_job(2, 2, 8);
    start_job(2);
    run_words(5, 1'b1, 1'b1, 1'b0);
    chk("t3_feed_latency", 64'(step0_cyc), 64'(last_fire_cyc + 1));
    chk("t3_done", {63'h0, done1}, 64'h1);
    chk("t3_q_empty", 64'(q.size()), 64'h0);

    // bad sizes
    start_job(3);
    @(negedge clk);
    chk("t4_err_s3", {63'h0, err1}, 64'h1);
    chk("t4_done_s3", {63'h0, done1}, 64'h0);
    chk("t4_readies_s3", {62'h0, a_ready1, b_ready1}, 64'h0);
    chk("t4_busy_s3", {63'h0, busy1}, 64'h0);
    start_job(0);
    @(negedge clk);
    chk("t4_err_s0", {63'h0, err1}, 64'h1);
    chk("t4_readies_s0", {62'h0, a_ready1, b_ready1}, 64'h0);
    push_job(2, 2, 8);
    start_job(2);
    @(negedge clk);
    chk("t4_err_clear", {63'h0, err1}, 64'h0);
    run_words(0, 1'b0, 1'b0, 1'b0);
    chk("t4_done", {63'h0, done1}, 64'h1);

    // async reset during step 1
    push_job(2, 2, 8);
    start_job(2);
    run_words(0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_outs_async", {a_out1, b_out1, am1, bm1, first1, last1}, 64'h0);
    chk("t5_busy_async", {63'h0, busy1}, 64'h0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("t5_idle_flags", {61'h0, busy1, done1, a_ready1}, 64'h0);
    push_job(2, 2, 8);
    start_job(2);
    run_words(0, 1'b0, 1'b0, 1'b0);
    chk("t5_done", {63'h0, done1}, 64'h1);
    chk("t5_q_empty", 64'(q.size()), 64'h0);

    // ARR=4, EW=16 wavefront
    sel = 1'b1;
    mlog.delete();
    push_job(4, 4, 16);
    start_job(4);
    run_words(0, 1'b0, 1'b0, 1'b0);
    chk("t6_done", {63'h0, done2}, 64'h1);
    chk("t6_q_empty", 64'(q.size()), 64'h0);
    chk("t6_steps", 64'(mlog.size()), 64'd7);
    mexp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    for (int i = 0; i < 7; i++)
      chk($sformatf("t6_mask%0d", i),
          {60'h0, (i < mlog.size()) ? mlog[i] : 4'hx}, {60'h0, mexp[i]});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
